// File: rtl/mips_hz_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Holds Tuse/Tnew encodings, field widths, PC reset value, the stage entry type
// and the saturating Tnew decrement used as entries age through the pipe.
package mips_hz_pkg;

  localparam int A_W    = 5;
  localparam int TNEW_W = 2;

  localparam logic [TNEW_W-1:0] TUSE_D = 2'd0;
  localparam logic [TNEW_W-1:0] TUSE_E = 2'd1;
  localparam logic [TNEW_W-1:0] TUSE_M = 2'd2;

  localparam logic [TNEW_W-1:0] TNEW_0 = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_1 = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_2 = 2'd2;

  localparam logic [31:0] PC_INIT = 32'h0000_3000;

  // One in-flight instruction's destination bookkeeping (PC is kept alongside,
  // since its width follows the data-width parameter).
  typedef struct packed {
    logic              wr;
    logic [A_W-1:0]    a3;
    logic [TNEW_W-1:0] tnew;
  } hz_ent_t;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One pipeline stage entry {wr, a3, tnew, pc} with synchronous reset.
// Ports: clk/rst, bubble (load an empty entry), nxt_ent/nxt_pc (incoming entry),
// ent/pc (held entry). Tnew is optionally decremented (saturating) on load.
module hz_stage_reg
  import mips_hz_pkg::*;
#(
  parameter int            DW       = 32,
  parameter bit            DEC_TNEW = 1'b1,
  parameter logic [DW-1:0] PC_RST   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bubble,
  input  hz_ent_t       nxt_ent,
  input  logic [DW-1:0] nxt_pc,
  output hz_ent_t       ent,
  output logic [DW-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
      pc  <= PC_RST;
    end else if (bubble) begin
      ent <= '0;
      pc  <= '0;
    end else begin
      // A write to $0 is architecturally a no-op, so it must never match.
      ent.wr   <= nxt_ent.wr & (nxt_ent.a3 != '0);
      ent.a3   <= nxt_ent.a3;
      ent.tnew <= DEC_TNEW ? sat_dec(nxt_ent.tnew) : nxt_ent.tnew;
      pc       <= nxt_pc;
    end
  end

endmodule

// File: rtl/wb_hazard_ctrl.sv
// Hazard controller: tracks E/M/W destinations, stalls decode on unready
// operands, forwards E/M/W results to decode, and drives the GRF write port.
// Ports: D_* decode request, GRF_RD*/E_Result/M_Result data sources,
// Stall/D_V*/D_Pend* decode outputs, W_* registered GRF write port.
module wb_hazard_ctrl #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] PC_INIT = mips_hz_pkg::PC_INIT
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic [4:0]    D_A1,
  input  logic [4:0]    D_A2,
  input  logic          D_Use1,
  input  logic          D_Use2,
  input  logic [1:0]    D_Tuse1,
  input  logic [1:0]    D_Tuse2,
  input  logic          D_Wr,
  input  logic [4:0]    D_A3,
  input  logic [1:0]    D_Tnew,
  input  logic [DW-1:0] D_PC,
  input  logic [DW-1:0] GRF_RD1,
  input  logic [DW-1:0] GRF_RD2,
  input  logic [DW-1:0] E_Result,
  input  logic [DW-1:0] M_Result,
  output logic          Stall,
  output logic [DW-1:0] D_V1,
  output logic [DW-1:0] D_V2,
  output logic          D_Pend1,
  output logic          D_Pend2,
  output logic          W_RFWr,
  output logic [4:0]    W_A3,
  output logic [DW-1:0] W_WD,
  output logic [DW-1:0] W_PC
);
  import mips_hz_pkg::*;

  typedef struct packed {
    logic          stall;
    logic          pend;
    logic [DW-1:0] val;
  } fwd_t;

  hz_ent_t       d_ent, e_ent, m_ent, w_ent;
  logic [DW-1:0] e_pc, m_pc, w_pc;
  logic [DW-1:0] w_wd;
  fwd_t          op1, op2;

  always_comb begin
    d_ent      = '0;
    d_ent.wr   = D_Wr;
    d_ent.a3   = D_A3;
    d_ent.tnew = D_Tnew;
  end

  // E captures decode as-is; its Tnew counts from entry into E.
  hz_stage_reg #(.DW(DW), .DEC_TNEW(1'b0), .PC_RST('0)) u_e (
    .clk(CLK), .rst(Reset), .bubble(Stall),
    .nxt_ent(d_ent), .nxt_pc(D_PC), .ent(e_ent), .pc(e_pc)
  );

  hz_stage_reg #(.DW(DW), .DEC_TNEW(1'b1), .PC_RST('0)) u_m (
    .clk(CLK), .rst(Reset), .bubble(1'b0),
    .nxt_ent(e_ent), .nxt_pc(e_pc), .ent(m_ent), .pc(m_pc)
  );

  hz_stage_reg #(.DW(DW), .DEC_TNEW(1'b1), .PC_RST(PC_INIT)) u_w (
    .clk(CLK), .rst(Reset), .bubble(1'b0),
    .nxt_ent(m_ent), .nxt_pc(m_pc), .ent(w_ent), .pc(w_pc)
  );

  always_ff @(posedge CLK) begin
    if (Reset) w_wd <= '0;
    else       w_wd <= M_Result;
  end

  // Nearest producer wins. A not-yet-ready producer either stalls decode or,
  // if the operand is consumed late enough, lets decode go on with the stale
  // GRF value flagged as pending so a later stage picks up the real result.
  function automatic fwd_t resolve(input logic          rd,
                                   input logic [4:0]    a,
                                   input logic [1:0]    tuse,
                                   input logic [DW-1:0] grf);
    fwd_t r;
    logic ok, hit_e, hit_m, hit_w;
    r     = '{stall: 1'b0, pend: 1'b0, val: grf};
    ok    = rd & (a != '0);
    hit_e = ok & e_ent.wr & (e_ent.a3 == a);
    hit_m = ok & m_ent.wr & (m_ent.a3 == a);
    hit_w = ok & w_ent.wr & (w_ent.a3 == a);
    if (hit_e) begin
      if (e_ent.tnew > tuse)        r.stall = 1'b1;
      else if (e_ent.tnew == TNEW_0) r.val  = E_Result;
      else                           r.pend = 1'b1;
    end else if (hit_m) begin
      if (m_ent.tnew > tuse)        r.stall = 1'b1;
      else if (m_ent.tnew == TNEW_0) r.val  = M_Result;
      else                           r.pend = 1'b1;
    end else if (hit_w) begin
      // GRF has no internal write-through, so W must be bypassed here.
      if (w_ent.tnew > tuse) r.stall = 1'b1;
      else                   r.val   = w_wd;
    end
    return r;
  endfunction

  always_comb begin
    op1 = resolve(D_Use1, D_A1, D_Tuse1, GRF_RD1);
    op2 = resolve(D_Use2, D_A2, D_Tuse2, GRF_RD2);
  end

  assign Stall   = op1.stall | op2.stall;
  assign D_V1    = op1.val;
  assign D_V2    = op2.val;
  assign D_Pend1 = op1.pend;
  assign D_Pend2 = op2.pend;

  assign W_RFWr = w_ent.wr;
  assign W_A3   = w_ent.a3;
  assign W_WD   = w_wd;
  assign W_PC   = w_pc;

endmodule

// File: tb/tb_wb_hazard_ctrl.sv
// Randomized + directed bench for wb_hazard_ctrl against an in-order
// instruction-list model of the E/M/W pipe.
module tb_wb_hazard_ctrl;
  localparam int          DW  = 32;
  localparam logic [31:0] PCI = 32'h0000_3000;

  logic          CLK = 1'b0;
  logic          Reset;
  logic [4:0]    D_A1, D_A2, D_A3;
  logic          D_Use1, D_Use2, D_Wr;
  logic [1:0]    D_Tuse1, D_Tuse2, D_Tnew;
  logic [DW-1:0] D_PC, GRF_RD1, GRF_RD2, E_Result, M_Result;
  logic          Stall, D_Pend1, D_Pend2, W_RFWr;
  logic [DW-1:0] D_V1, D_V2, W_WD, W_PC;
  logic [4:0]    W_A3;

  always #5 CLK = ~CLK;

  wb_hazard_ctrl #(.DW(DW), .PC_INIT(PCI)) dut (
    .CLK(CLK), .Reset(Reset),
    .D_A1(D_A1), .D_A2(D_A2), .D_Use1(D_Use1), .D_Use2(D_Use2),
    .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2), .D_Wr(D_Wr), .D_A3(D_A3),
    .D_Tnew(D_Tnew), .D_PC(D_PC), .GRF_RD1(GRF_RD1), .GRF_RD2(GRF_RD2),
    .E_Result(E_Result), .M_Result(M_Result), .Stall(Stall),
    .D_V1(D_V1), .D_V2(D_V2), .D_Pend1(D_Pend1), .D_Pend2(D_Pend2),
    .W_RFWr(W_RFWr), .W_A3(W_A3), .W_WD(W_WD), .W_PC(W_PC)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: list of the three instructions past decode, youngest first.
  // Each keeps the Tnew it had on entering E; remaining wait = Tnew - age.
  typedef struct {
    logic        wr;
    logic [4:0]  a3;
    int          tnew;
    logic [31:0] pc;
  } ins_t;

  ins_t        pipe[3];
  logic [31:0] wwd;

  function automatic int remain(input int age);
    return (pipe[age].tnew > age) ? pipe[age].tnew - age : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 5'd0, 0, 32'd0};
    pipe[2].pc = PCI;
    wwd = 32'd0;
  endtask

  task automatic model_op(input logic u, input logic [4:0] a, input int tuse,
                          input logic [31:0] grf, output logic st,
                          output logic pd, output logic [31:0] v);
    int hit;
    int r;
    st = 1'b0; pd = 1'b0; v = grf; hit = -1;
    for (int i = 2; i >= 0; i--)
      if (pipe[i].wr && pipe[i].a3 == a) hit = i;
    if (u && a != 5'd0 && hit >= 0) begin
      r = remain(hit);
      if (r > tuse)      st = 1'b1;
      else if (hit == 2) v  = wwd;
      else if (r == 0)   v  = (hit == 0) ? E_Result : M_Result;
      else               pd = 1'b1;
    end
  endtask

  // Compare everything against the model, then clock and advance the model.
  task automatic step();
    logic s1, p1, s2, p2;
    logic [31:0] v1, v2;
    #1;
    model_op(D_Use1, D_A1, int'(D_Tuse1), GRF_RD1, s1, p1, v1);
    model_op(D_Use2, D_A2, int'(D_Tuse2), GRF_RD2, s2, p2, v2);
    chk_eq("stall", Stall, s1 | s2);
    chk_eq("v1", D_V1, v1);
    chk_eq("v2", D_V2, v2);
    chk_eq("pend1", D_Pend1, p1);
    chk_eq("pend2", D_Pend2, p2);
    chk_eq("w_rfwr", W_RFWr, pipe[2].wr);
    chk_eq("w_a3", W_A3, pipe[2].wr ? pipe[2].a3 : W_A3 & 5'd0 | pipe[2].a3);
    chk_eq("w_wd", W_WD, wwd);
    chk_eq("w_pc", W_PC, pipe[2].pc);
    @(posedge CLK);
    if (Reset) model_reset();
    else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (s1 | s2) pipe[0] = '{1'b0, 5'd0, 0, 32'd0};
      else         pipe[0] = '{D_Wr && D_A3 != 5'd0, D_A3, int'(D_Tnew), D_PC};
      wwd = M_Result;
    end
    @(negedge CLK);
  endtask

  task automatic set_d(input logic u1, input logic [4:0] a1, input logic [1:0] t1,
                       input logic u2, input logic [4:0] a2, input logic [1:0] t2,
                       input logic wr, input logic [4:0] a3, input logic [1:0] tn);
    D_Use1 = u1; D_A1 = a1; D_Tuse1 = t1;
    D_Use2 = u2; D_A2 = a2; D_Tuse2 = t2;
    D_Wr = wr; D_A3 = a3; D_Tnew = tn;
    D_PC = D_PC + 32'd4;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    Reset = 1'b1; D_PC = PCI;
    GRF_RD1 = 32'h1111_0001; GRF_RD2 = 32'h2222_0002;
    E_Result = 32'hE0E0_0000; M_Result = 32'h3030_0000;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); @(negedge CLK);
    model_reset();
    step();
    Reset = 1'b0;
    #1;
    chk_eq("rst_rfwr", W_RFWr, 1'b0);
    chk_eq("rst_pc", W_PC, PCI);
    chk_eq("rst_wd", W_WD, 32'd0);

    // ALU $8 then beq $8: one stall, then M forward.
    set_d(0, 0, 0, 0, 0, 0, 1, 5'd8, 2'd1); step();
    set_d(1, 5'd8, 2'd0, 0, 0, 0, 0, 0, 0); #1;
    chk_eq("alu_stall", Stall, 1'b1);
    step();
    M_Result = 32'h0000_1234; #1;
    chk_eq("alu_nostall", Stall, 1'b0);
    chk_eq("alu_fwd_m", D_V1, 32'h0000_1234);
    step();
    nops(3);

    // lw $9 then addu $9 (Tuse 1): stall, then pending, then GRF write.
    set_d(0, 0, 0, 0, 0, 0, 1, 5'd9, 2'd2); step();
    set_d(1, 5'd9, 2'd1, 0, 0, 0, 1, 5'd11, 2'd1); #1;
    chk_eq("lw_stall", Stall, 1'b1);
    step();
    M_Result = 32'hDEAD_BEEF; #1;
    chk_eq("lw_nostall", Stall, 1'b0);
    chk_eq("lw_pend", D_Pend1, 1'b1);
    step();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk_eq("lw_w_rfwr", W_RFWr, 1'b1);
    chk_eq("lw_w_a3", W_A3, 5'd9);
    chk_eq("lw_w_wd", W_WD, 32'hDEAD_BEEF);
    step();
    nops(3);

    // lui $10 then reader Tuse 0: E forward, no stall.
    set_d(0, 0, 0, 0, 0, 0, 1, 5'd10, 2'd0); step();
    set_d(1, 5'd10, 2'd0, 1, 5'd10, 2'd0, 0, 0, 0);
    E_Result = 32'hABCD_0000; #1;
    chk_eq("lui_stall", Stall, 1'b0);
    chk_eq("lui_v1", D_V1, 32'hABCD_0000);
    chk_eq("lui_v2", D_V2, 32'hABCD_0000);
    step();
    nops(3);

    // Writes to $0 never match or commit.
    set_d(0, 0, 0, 0, 0, 0, 1, 5'd0, 2'd2); step();
    set_d(1, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    GRF_RD1 = 32'd0; #1;
    chk_eq("r0_stall", Stall, 1'b0);
    chk_eq("r0_v1", D_V1, 32'd0);
    step(); step();
    chk_eq("r0_rfwr", W_RFWr, 1'b0);
    nops(2);

    // $7 ALU then $7 load: E (load) wins over M.
    set_d(0, 0, 0, 0, 0, 0, 1, 5'd7, 2'd1); step();
    set_d(0, 0, 0, 0, 0, 0, 1, 5'd7, 2'd2); step();
    set_d(1, 5'd7, 2'd1, 0, 0, 0, 0, 0, 0);
    M_Result = 32'h7777_7777; GRF_RD1 = 32'h0BAD_0007; #1;
    chk_eq("prio_stall", Stall, 1'b1);
    chk_eq("prio_v1", D_V1, 32'h0BAD_0007);
    step();

    // Randomized traffic on a small register set for dense hazards.
    for (int n = 0; n < 600; n++) begin
      Reset = ($urandom_range(0, 59) == 0);
      set_d(1'($urandom), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
            1'($urandom), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
            1'($urandom), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
      GRF_RD1 = $urandom; GRF_RD2 = $urandom;
      E_Result = $urandom; M_Result = $urandom;
      step();
    end

    // Reset held two cycles mid-stream.
    set_d(1, 5'd2, 2'd0, 0, 0, 0, 1, 5'd2, 2'd2);
    Reset = 1'b1; step(); step();
    Reset = 1'b0; GRF_RD1 = 32'h5555_0005; #1;
    chk_eq("mid_rst_rfwr", W_RFWr, 1'b0);
    chk_eq("mid_rst_pc", W_PC, PCI);
    chk_eq("mid_rst_stall", Stall, 1'b0);
    chk_eq("mid_rst_v1", D_V1, 32'h5555_0005);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_hazard_ctrl.md
Name: wb_hazard_ctrl

Overview:
Tracks the destination register of every instruction in flight in the E, M and W stages of the pipelined MIPS core. It drives the GRF write port (W_RFWr/W_A3/W_WD/W_PC) from the W stage. It raises Stall when a decode-stage read depends on a result that is not yet available. Otherwise it supplies D-stage operands forwarded from E/M/W in place of the raw GRF read data.

Parameters:
DW, 32, data width of register values.
PC_INIT, 32'h00003000, reset value of W_PC.

Ports:
CLK  in  1  clock; all state updates on posedge
Reset  in  1  synchronous, active-high; clears all stage entries
D_A1  in  5  decode rs address
D_A2  in  5  decode rt address
D_Use1  in  1  decode instruction reads rs
D_Use2  in  1  decode instruction reads rt
D_Tuse1  in  2  cycles after D before rs is consumed (0 = D, 1 = E, 2 = M)
D_Tuse2  in  2  same for rt
D_Wr  in  1  decode instruction writes a GPR
D_A3  in  5  decode destination register
D_Tnew  in  2  cycles after entering E until result exists (0 = lui/jal, 1 = ALU, 2 = load)
D_PC  in  DW  decode PC
GRF_RD1  in  DW  raw GRF read for D_A1
GRF_RD2  in  DW  raw GRF read for D_A2
E_Result  in  DW  E-stage result, valid when E entry Tnew = 0
M_Result  in  DW  M-stage result (ALU passthrough or DM read data)
Stall  out  1  freeze PC and IF/ID; combinational
D_V1  out  DW  forwarded rs value
D_V2  out  DW  forwarded rt value
D_Pend1  out  1  D_V1 is stale; producer's result arrives later and must be re-forwarded downstream
D_Pend2  out  1  same for rt
W_RFWr  out  1  GRF write enable
W_A3  out  5  GRF write address
W_WD  out  DW  GRF write data
W_PC  out  DW  PC of the W instruction

Behaviour:
- Stage entry {Wr, A3, Tnew, PC}. E, M and W are registered. Entry Wr is forced to 0 when A3 = 0.
- Reset (synchronous): all entries Wr = 0, A3 = 0, Tnew = 0. Outputs: W_RFWr = 0, W_A3 = 0, W_WD = 0, W_PC = PC_INIT. Reset overrides a concurrent stall or advance.
- Each posedge, not Reset:
  - M <= E with Tnew = sat_dec(E.Tnew).
  - W <= M with Tnew = sat_dec(M.Tnew).
  - W_WD <= M_Result.
  - sat_dec(0) = 0.
- E update:
  - Stall = 0: E <= {D_Wr, D_A3, D_Tnew, D_PC}.
  - Stall = 1: E <= bubble (Wr = 0, A3 = 0, Tnew = 0, PC = 0).
  - M and W always advance.
- W_RFWr = W.Wr, W_A3 = W.A3, W_PC = W.PC; all registered, no combinational path from D.
- Match for operand k on stage S: D_Usek & S.Wr & (S.A3 = D_Ak) & (D_Ak != 0). Priority E > M > W; only the nearest match counts.
- Stall term k = nearest match exists and its Tnew > D_Tusek. Stall = term1 | term2.
- D_Vk, taken from the nearest match:
  - E match with Tnew = 0: E_Result.
  - M match with Tnew = 0: M_Result.
  - W match: W_WD.
  - No match: GRF_RDk.
  - Nearest match with Tnew > 0 and no stall: GRF_RDk, with D_Pendk = 1.
  - D_Pendk = 0 in every other case.
- W forwarding is mandatory because the GRF writes at posedge and reads combinationally without internal bypass.
- Address 0 never matches, never stalls, and always reads GRF_RDk (0).
- Both operands naming the same register resolve independently and identically.

Decomposition:
- Package mips_hz_pkg: TUSE_D/E/M = 0/1/2, TNEW_0/1/2, entry field widths, PC_INIT.
- One sub-module hz_stage_reg: holds one entry with sync reset, bubble input and saturating Tnew decrement. Instantiated for E, M and W.

Test Plan:
- Reset held 2 cycles mid-stream -> W_RFWr = 0, W_PC = 32'h00003000, Stall = 0, D_V1 = GRF_RD1.
- ALU write $8 (Tnew 1), next instruction beq reads $8 (Tuse 0) -> Stall = 1 for 1 cycle, then D_V1 = M_Result = 32'h0000_1234.
- lw $9 (Tnew 2), next addu reads $9 (Tuse 1) -> Stall 1 cycle, bubble in E, then D_Pend1 = 1 with no stall. Two cycles after the lw enters E: W_RFWr = 1, W_A3 = 9, W_WD = DM data.
- lui $10 (Tnew 0), next instruction reads $10 with Tuse 0 -> no stall, D_V1 = E_Result = 32'hABCD_0000.
- Writes to $0 with Tnew 2, reader of $0 with Tuse 0 -> Stall = 0, D_V1 = 0, W_RFWr = 0.
- $7 in M (ALU, Tnew 0) and $7 in E (load, Tnew 2), reader with Tuse 1 -> E takes priority, Stall = 1, M value not forwarded.
